// File: rtl/spi_slave.sv
// SPI target core oversampling sclk/ss_n/mosi in wb_clk_in, with a Wishbone register slave.
// Optional LSB-first mode: define SPI_SLAVE_LSB_FIRST_EN to make CTRL bit4 (lsb) writable.
module spi_slave #(
    parameter int CHAR_LEN    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        wb_clk_in,
    input  logic        wb_rst_in,
    input  logic [4:0]  wb_adr_in,
    input  logic [31:0] wb_dat_in,
    input  logic [3:0]  wb_sel_in,
    input  logic        wb_we_in,
    input  logic        wb_stb_in,
    input  logic        wb_cyc_in,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_out,
    output logic        wb_int_o,
    input  logic        sclk_in,
    input  logic        ss_n_in,
    input  logic        mosi_in,
    output logic        miso_out,
    output logic        miso_oe
);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;
    localparam int CW = $clog2(CHAR_LEN + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(CHAR_LEN - 1);

    logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
    logic sclk_prev_q, ss_prev_q;
    logic [0:0] state_q, state_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [CHAR_LEN-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_q, rx_d, tx_q, tx_d;
    logic cpol_q, cpol_d, cpha_q, cpha_d, ie_q, ie_d, en_q, en_d;
    logic rx_full_q, rx_full_d, tx_empty_q, tx_empty_d, overrun_q, overrun_d;
    logic int_q, int_d, ack_q, ack_d, reload;
    logic [31:0] dat_q, dat_d, rd_mux;
    logic lsb, busy, unused_w;

    always_ff @(posedge wb_clk_in or negedge wb_rst_in) begin
        if (!wb_rst_in) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n_in};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            ss_prev_q   <= ss_sync_q[SYNC_STAGES-1];
        end
    end

    logic sclk_s, ss_s, mosi_s, ss_fall, lead_e, trail_e, sample_e, shift_e;
    assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s     = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign ss_fall  = ss_prev_q & ~ss_s;
    // Leading edge is the one that leaves the idle (cpol) level.
    assign lead_e   = cpol_q ? (sclk_prev_q & ~sclk_s) : (~sclk_prev_q & sclk_s);
    assign trail_e  = cpol_q ? (~sclk_prev_q & sclk_s) : (sclk_prev_q & ~sclk_s);
    assign sample_e = cpha_q ? trail_e : lead_e;
    assign shift_e  = cpha_q ? lead_e : trail_e;
    assign busy     = (state_q == ST_ACTIVE);

    logic access, wr, rd_rx, wr_tx, wr_ctrl, wr_stat;
    assign access  = wb_cyc_in & wb_stb_in & ~ack_q;
    assign wr      = access & wb_we_in & wb_sel_in[0];
    assign rd_rx   = access & ~wb_we_in & (wb_adr_in == 5'h00);
    assign wr_tx   = wr & (wb_adr_in == 5'h04);
    assign wr_ctrl = wr & (wb_adr_in == 5'h10) & ~busy;
    assign wr_stat = wr & (wb_adr_in == 5'h14);
    assign unused_w = &{1'b0, wb_sel_in[3:1], wb_dat_in};

`ifdef SPI_SLAVE_LSB_FIRST_EN
    logic lsb_q;
    always_ff @(posedge wb_clk_in or negedge wb_rst_in) begin
        if (!wb_rst_in)   lsb_q <= 1'b0;
        else if (wr_ctrl) lsb_q <= wb_dat_in[4];
    end
    assign lsb = lsb_q;
`else
    assign lsb = 1'b0;
`endif

    logic [CHAR_LEN-1:0] rx_frame, tx_shift;
    assign rx_frame = lsb ? {mosi_s, rx_sr_q[CHAR_LEN-1:1]} : {rx_sr_q[CHAR_LEN-2:0], mosi_s};
    assign tx_shift = lsb ? {1'b0, tx_sr_q[CHAR_LEN-1:1]} : {tx_sr_q[CHAR_LEN-2:0], 1'b0};

    always_comb begin
        state_d = state_q;  bit_cnt_d = bit_cnt_q;
        tx_sr_d = tx_sr_q;  rx_sr_d = rx_sr_q;  rx_d = rx_q;  tx_d = tx_q;
        cpol_d = cpol_q;  cpha_d = cpha_q;  ie_d = ie_q;  en_d = en_q;
        rx_full_d = rx_full_q;  tx_empty_d = tx_empty_q;  overrun_d = overrun_q;
        int_d = int_q;  reload = 1'b0;
        if (wr_ctrl) {en_d, ie_d, cpha_d, cpol_d} = wb_dat_in[3:0];
        if (rd_rx) begin
            rx_full_d = 1'b0;
            int_d     = 1'b0;
        end
        if (wr_stat && wb_dat_in[2]) overrun_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_q && ss_fall) begin
                    state_d   = ST_ACTIVE;
                    bit_cnt_d = '0;
                    reload    = 1'b1;
                end
            end
            default: begin
                if (ss_s || !en_q) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                end else if (shift_e) begin
                    // First bit was presented at load; its shift edge is skipped.
                    if (bit_cnt_q != '0) tx_sr_d = tx_shift;
                end else if (sample_e) begin
                    rx_sr_d = rx_frame;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        reload    = 1'b1;
                        if (ie_q) int_d = 1'b1;
                        if (!rx_full_q || rd_rx) begin
                            rx_d      = rx_frame;
                            rx_full_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
            end
        endcase
        if (reload) begin
            tx_sr_d    = tx_empty_q ? '0 : tx_q;
            tx_empty_d = 1'b1;
        end
        // A TX write racing a reload wins the empty flag; the reload used the old TX.
        if (wr_tx) begin
            tx_d       = wb_dat_in[CHAR_LEN-1:0];
            tx_empty_d = 1'b0;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (wb_adr_in)
            5'h00:   rd_mux[CHAR_LEN-1:0] = rx_q;
            5'h04:   rd_mux[CHAR_LEN-1:0] = tx_q;
            5'h10:   rd_mux[4:0] = {lsb, en_q, ie_q, cpha_q, cpol_q};
            5'h14:   rd_mux[3:0] = {busy, overrun_q, tx_empty_q, rx_full_q};
            default: rd_mux = '0;
        endcase
    end

    assign ack_d = access;
    assign dat_d = access ? rd_mux : dat_q;

    always_ff @(posedge wb_clk_in or negedge wb_rst_in) begin
        if (!wb_rst_in) begin
            state_q <= ST_IDLE;  bit_cnt_q <= '0;
            tx_sr_q <= '0;  rx_sr_q <= '0;  rx_q <= '0;  tx_q <= '0;
            cpol_q <= 1'b0;  cpha_q <= 1'b0;  ie_q <= 1'b0;  en_q <= 1'b0;
            rx_full_q <= 1'b0;  tx_empty_q <= 1'b1;  overrun_q <= 1'b0;
            int_q <= 1'b0;  ack_q <= 1'b0;  dat_q <= '0;
        end else begin
            state_q <= state_d;  bit_cnt_q <= bit_cnt_d;
            tx_sr_q <= tx_sr_d;  rx_sr_q <= rx_sr_d;  rx_q <= rx_d;  tx_q <= tx_d;
            cpol_q <= cpol_d;  cpha_q <= cpha_d;  ie_q <= ie_d;  en_q <= en_d;
            rx_full_q <= rx_full_d;  tx_empty_q <= tx_empty_d;  overrun_q <= overrun_d;
            int_q <= int_d;  ack_q <= ack_d;  dat_q <= dat_d;
        end
    end

    assign wb_dat_o   = dat_q;
    assign wb_ack_out = ack_q;
    assign wb_int_o   = int_q;
    assign miso_out   = lsb ? tx_sr_q[0] : tx_sr_q[CHAR_LEN-1];
    assign miso_oe    = en_q & ~ss_s;
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: bit-banged SPI master plus Wishbone register accesses.
module tb_spi_slave;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic        we, stb, cyc;
    logic [31:0] rdat;
    logic        ack, irq;
    logic        sclk, ss_n, mosi;
    logic        miso, miso_oe;

    int checks = 0;
    int errors = 0;
    logic [31:0] rv;
    logic [7:0]  mi;

    spi_slave #(.CHAR_LEN(8), .SYNC_STAGES(2)) dut (
        .wb_clk_in(clk), .wb_rst_in(rst_n), .wb_adr_in(adr), .wb_dat_in(wdat),
        .wb_sel_in(sel), .wb_we_in(we), .wb_stb_in(stb), .wb_cyc_in(cyc),
        .wb_dat_o(rdat), .wb_ack_out(ack), .wb_int_o(irq),
        .sclk_in(sclk), .ss_n_in(ss_n), .mosi_in(mosi),
        .miso_out(miso), .miso_oe(miso_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wb_cycle(input logic [4:0] a, input logic w, input logic [31:0] d,
                            output logic [31:0] q);
        int n;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = 4'hF;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 8);
        check("wb_ack", {31'd0, ack}, 32'd1);
        q = rdat;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        logic [31:0] q;
        wb_cycle(a, 1'b1, d, q);
    endtask

    task automatic rd_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] q;
        wb_cycle(a, 1'b0, 32'd0, q);
        check(tag, q, exp);
    endtask

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    // Master side: drives mosi MSB first, captures miso on its sample edge.
    task automatic spi_bits(input logic [7:0] mo, input int nbits, input logic cp,
                            input logic ph, output logic [7:0] got);
        got = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!ph) begin
                mosi = mo[i]; half();
                sclk = ~cp; got[i] = miso; half();
                sclk = cp;
            end else begin
                sclk = ~cp; mosi = mo[i]; half();
                sclk = cp; got[i] = miso; half();
            end
        end
    endtask

    task automatic frame(input logic [7:0] mo, input logic cp, input logic ph,
                         output logic [7:0] got);
        ss_n = 1'b0; half();
        spi_bits(mo, 8, cp, ph, got);
        half(); ss_n = 1'b1; half();
    endtask

    initial begin
        rst_n = 1'b0; adr = '0; wdat = '0; sel = '0; we = 1'b0; stb = 1'b0; cyc = 1'b0;
        sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dat", rdat, 32'd0);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_int", {31'd0, irq}, 32'd0);
        check("rst_miso", {30'd0, miso, miso_oe}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        rd_check("rst_stat", 5'h14, 32'h02);
        rd_check("rst_ctrl", 5'h10, 32'h00);

        // Mode 0: TX=A5, master sends 3C
        wb_write(5'h10, 32'h0C);
        wb_write(5'h04, 32'hA5);
        rd_check("tx_written_stat", 5'h14, 32'h00);
        ss_n = 1'b0; half();
        check("m0_oe", {31'd0, miso_oe}, 32'd1);
        rd_check("m0_busy_stat", 5'h14, 32'h0A);
        spi_bits(8'h3C, 8, 1'b0, 1'b0, mi);
        half(); ss_n = 1'b1; half();
        check("m0_miso_data", {24'd0, mi}, 32'hA5);
        check("m0_int", {31'd0, irq}, 32'd1);
        rd_check("m0_stat", 5'h14, 32'h03);
        rd_check("m0_rx", 5'h00, 32'h3C);
        check("m0_int_clr", {31'd0, irq}, 32'd0);
        rd_check("m0_stat_clr", 5'h14, 32'h02);

        // Mode 3: TX=81, master sends 7E
        sclk = 1'b1;
        wb_write(5'h10, 32'h0F);
        rd_check("m3_ctrl", 5'h10, 32'h0F);
        wb_write(5'h04, 32'h81);
        frame(8'h7E, 1'b1, 1'b1, mi);
        check("m3_miso_data", {24'd0, mi}, 32'h81);
        rd_check("m3_rx", 5'h00, 32'h7E);

        // Back-to-back frames, TX never written: zeros out, overrun on second
        sclk = 1'b0;
        wb_write(5'h10, 32'h0C);
        ss_n = 1'b0; half();
        rd_check("b2b_stat_active", 5'h14, 32'h0A);
        spi_bits(8'h11, 8, 1'b0, 1'b0, mi);
        check("b2b_miso1", {24'd0, mi}, 32'h00);
        spi_bits(8'h22, 8, 1'b0, 1'b0, mi);
        check("b2b_miso2", {24'd0, mi}, 32'h00);
        half(); ss_n = 1'b1; half();
        rd_check("b2b_stat_ovr", 5'h14, 32'h07);
        wb_write(5'h14, 32'h04);
        rd_check("b2b_stat_ovr_clr", 5'h14, 32'h03);
        rd_check("b2b_rx_first", 5'h00, 32'h11);
        rd_check("b2b_stat_end", 5'h14, 32'h02);

        // Abort after 4 bits, then a clean frame
        wb_write(5'h04, 32'h5A);
        ss_n = 1'b0; half();
        spi_bits(8'hF0, 4, 1'b0, 1'b0, mi);
        half(); ss_n = 1'b1; half();
        rd_check("abort_stat", 5'h14, 32'h02);
        check("abort_int", {31'd0, irq}, 32'd0);
        wb_write(5'h04, 32'hC3);
        frame(8'h96, 1'b0, 1'b0, mi);
        check("after_abort_miso", {24'd0, mi}, 32'hC3);
        check("after_abort_int", {31'd0, irq}, 32'd1);
        rd_check("after_abort_rx", 5'h00, 32'h96);

        // Reset in the middle of a frame
        wb_write(5'h04, 32'hFF);
        ss_n = 1'b0; half();
        spi_bits(8'h00, 3, 1'b0, 1'b0, mi);
        half();
        check("midframe_miso", {30'd0, miso, miso_oe}, 32'h3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_miso", {30'd0, miso, miso_oe}, 32'd0);
        check("mid_rst_int_ack", {30'd0, irq, ack}, 32'd0);
        check("mid_rst_dat", rdat, 32'd0);
        repeat (2) @(negedge clk);
        ss_n = 1'b1; sclk = 1'b0;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        rd_check("post_rst_ctrl", 5'h10, 32'h00);
        rd_check("post_rst_stat", 5'h14, 32'h02);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
SPI slave/target core, the far end of the team's SPI master link. It receives MOSI and drives MISO under an external master's sclk and active-low slave select. SPI inputs are oversampled in the Wishbone clock domain; no second clock exists. Receive data, transmit data, control and status registers are exposed through the same Wishbone register slave style as the master core.

Parameters:
CHAR_LEN, 8, bits per SPI frame; legal range 2..32.
SYNC_STAGES, 2, synchronizer flops on sclk_in, ss_n_in and mosi_in; minimum 2.

Ports:
wb_clk_in  input  1  system clock; all logic on its rising edge
wb_rst_in  input  1  asynchronous, active-low reset (0 = reset)
wb_adr_in  input  5  register byte address
wb_dat_in  input  32  write data
wb_sel_in  input  4  byte selects; only bit 0 is used (all registers are at most 8 bits wide when CHAR_LEN=8; otherwise the full word is written)
wb_we_in  input  1  write enable
wb_stb_in  input  1  strobe
wb_cyc_in  input  1  cycle
wb_dat_o  output  32  registered read data
wb_ack_out  output  1  acknowledge
wb_int_o  output  1  interrupt
sclk_in  input  1  SPI clock from the master
ss_n_in  input  1  slave select, active low
mosi_in  input  1  serial data in
miso_out  output  1  serial data out
miso_oe  output  1  MISO output enable = enabled and selected (synchronized ss_n low)

Behaviour:
- Reset (wb_rst_in=0): all registers clear; tx_empty=1; wb_dat_o=0, wb_ack_out=0, wb_int_o=0, miso_out=0, miso_oe=0.
- Register map:
  - 0x00 RX: read-only; bits CHAR_LEN-1:0 hold the last received frame.
  - 0x04 TX: read/write; holds the next frame to transmit.
  - 0x10 CTRL: bit0 cpol, bit1 cpha, bit2 ie, bit3 en, bit4 lsb (see Optional Feature).
  - 0x14 STAT: bit0 rx_full, bit1 tx_empty, bit2 overrun, bit3 busy. Writing 1 to bit2 clears overrun.
  - Any other address reads 0.
- Wishbone access:
  - wb_ack_out <= cyc & stb & ~wb_ack_out, giving one wait state.
  - A write commits, and a read side effect occurs, only when cyc & stb & ~wb_ack_out.
  - wb_dat_o is registered and valid together with wb_ack_out.
  - Reading RX clears rx_full and deasserts wb_int_o.
  - Writing TX clears tx_empty.
  - Writing CTRL while busy=1 is ignored.
- Synchronizers: sclk_in, ss_n_in and mosi_in each pass through SYNC_STAGES flops. Edge detection compares the last two synchronized sclk values. The master's sclk period must be at least 8 wb_clk_in periods.
- Edge roles: leading edge = sclk leaves the cpol level. cpha=0: sample on leading, shift on trailing. cpha=1: shift on leading, sample on trailing.
- States: IDLE and ACTIVE.
  - IDLE -> ACTIVE when en=1 and the synchronized ss_n falls. On entry: bit_cnt=0, busy=1, and the tx shift register loads TX if tx_empty=0, else all zeros; tx_empty is set.
  - ACTIVE -> IDLE on synchronized ss_n rise or en=0. This is an abort: a partial frame is discarded, RX/rx_full are untouched, busy=0.
- miso_out = shift-register MSB (or LSB when lsb=1). A shift edge is ignored while bit_cnt=0, so the first bit is already presented at load.
- Sample edge:
  - Synchronized mosi shifts into the rx shift register and bit_cnt increments.
  - When bit_cnt reaches CHAR_LEN, the frame completes:
    - If rx_full=0: RX <= frame, rx_full=1.
    - Else: the frame is discarded and overrun=1.
    - In both cases: bit_cnt=0, the tx register reloads as on entry (supports back-to-back frames under continuous ss_n low), and wb_int_o is set if ie=1.
- Simultaneous events:
  - A frame completion in the same cycle as an RX read: RX takes the new frame and rx_full stays 1; the read returns the old value.
  - A TX write in the same cycle as a reload: the reload uses the old TX and tx_empty ends at 0.

Optional Feature:
SPI_SLAVE_LSB_FIRST_EN: when defined, CTRL bit4 (lsb) is writable and readable; lsb=1 transmits and receives LSB first. When undefined, bit4 reads 0, writes are ignored, and the core is MSB-first only.

Test Plan:
- Mode 0, CHAR_LEN=8, TX=0xA5, master sends 0x3C -> master receives 0xA5; RX=0x3C; rx_full=1; wb_int_o=1 with ie=1; RX read clears both.
- Mode 3 (cpol=1, cpha=1), TX=0x81, master sends 0x7E -> master receives 0x81; RX=0x7E.
- Two back-to-back frames with ss_n held low, no RX read in between -> RX keeps the first frame; overrun=1; writing STAT bit2 clears it.
- ss_n raised after 4 sclk cycles -> rx_full stays 0; busy=0; next full frame is received correctly.
- TX not written before a frame -> master receives 0x00; tx_empty=1 throughout.
- Reset asserted mid-frame -> all outputs 0 immediately; CTRL=0; tx_empty=1.
